// File: rtl/tile_route_pkg.sv
// Shared definitions for the tile routing dispatcher: routing modes and
// width helpers for the packed decision record {route, tileX, tileY, score}.
package tile_route_pkg;

  typedef enum logic [1:0] {
    MODE_THRESHOLD   = 2'd0,
    MODE_FORCE_CNN   = 2'd1,
    MODE_FORCE_LIGHT = 2'd2,
    MODE_INVERTED    = 2'd3
  } route_mode_e;

  // Index width with a floor of one bit so single-entry dimensions still get a port.
  function automatic int unsigned fieldWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned scoreWidth(input int unsigned tileW, input int unsigned tileH);
    return $clog2((tileW - 1) * tileH + 1);
  endfunction

  function automatic int unsigned decisionWidth(input int unsigned tx, input int unsigned ty,
                                                input int unsigned tileW, input int unsigned tileH);
    return 1 + fieldWidth(tx) + fieldWidth(ty) + scoreWidth(tileW, tileH);
  endfunction

endpackage

// File: rtl/route_decision_fifo.sv
// Small decision queue: register-array FIFO with the head entry driven straight
// from storage; head reads as zero while empty.
module route_decision_fifo
  import tile_route_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic                           iPush,
  input  logic [WIDTH-1:0]               iData,
  input  logic                           iPop,
  output logic [WIDTH-1:0]               oData,
  output logic                           oFull,
  output logic                           oEmpty,
  output logic [$clog2(DEPTH+1)-1:0]     oCount
);

  localparam int unsigned PW = fieldWidth(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr, rdPtr;
  logic [CW-1:0]    count;
  logic             doPush, doPop;

  always_comb begin
    oFull  = (count == CW'(DEPTH));
    oEmpty = (count == '0);
    doPush = iPush & ~oFull;
    doPop  = iPop & ~oEmpty;
    oData  = oEmpty ? '0 : mem[rdPtr];
    oCount = count;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= iData;
        wrPtr      <= (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + PW'(1);
      end
      if (doPop) rdPtr <= (rdPtr == PW'(DEPTH - 1)) ? '0 : rdPtr + PW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tile_route_dispatcher.sv
// Streaming tile edge scorer: counts horizontal edge hits per tile across a band
// of tiles and queues one CNN/light routing decision per completed tile.
module tile_route_dispatcher
  import tile_route_pkg::*;
#(
  parameter int unsigned PIX_W             = 8,
  parameter int unsigned IMG_WIDTH         = 32,
  parameter int unsigned IMG_HEIGHT        = 16,
  parameter int unsigned TILE_WIDTH        = 16,
  parameter int unsigned TILE_HEIGHT       = 16,
  parameter int unsigned EDGE_THRESHOLD    = 60,
  parameter int unsigned ROUTING_THRESHOLD = 80,
  parameter int unsigned DEC_DEPTH         = IMG_WIDTH / TILE_WIDTH,
  localparam int unsigned TX  = IMG_WIDTH / TILE_WIDTH,
  localparam int unsigned TY  = IMG_HEIGHT / TILE_HEIGHT,
  localparam int unsigned TXW = fieldWidth(TX),
  localparam int unsigned TYW = fieldWidth(TY),
  localparam int unsigned SW  = scoreWidth(TILE_WIDTH, TILE_HEIGHT)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [PIX_W-1:0] iData,
  input  logic             iValid,
  input  logic             iSof,
  output logic             oReady,
  input  logic [1:0]       iMode,
  output logic             oDecValid,
  input  logic             iDecReady,
  output logic             oRouteToCnn,
  output logic [TXW-1:0]   oTileX,
  output logic [TYW-1:0]   oTileY,
  output logic [SW-1:0]    oScore,
  output logic             oFrameDone
);

  localparam int unsigned CW   = fieldWidth(TILE_WIDTH);
  localparam int unsigned RW   = fieldWidth(TILE_HEIGHT);
  localparam int unsigned DW   = decisionWidth(TX, TY, TILE_WIDTH, TILE_HEIGHT);
  localparam int unsigned CNTW = $clog2(DEC_DEPTH + 1);

  // Position is kept as (column-in-tile, tile column, row-in-tile, tile row) to avoid dividers.
  logic [CW-1:0]    col, colEff, colNext;
  logic [TXW-1:0]   tx, txEff, txNext;
  logic [RW-1:0]    row, rowEff, rowNext;
  logic [TYW-1:0]   ty, tyEff, tyNext;
  logic [PIX_W-1:0] prevPix;
  logic [SW-1:0]    score [TX];
  logic [SW-1:0]    baseScore, scoreNext;
  logic [PIX_W:0]   absDiff;
  logic             accept, edgeHit, tileDone, frameEnd, routeCnn, push, qFull, qEmpty;
  logic [CNTW-1:0]  qCount;
  logic [DW-1:0]    decIn, decOut;

  always_comb begin
    accept  = iValid & oReady;
    colEff  = iSof ? '0 : col;
    txEff   = iSof ? '0 : tx;
    rowEff  = iSof ? '0 : row;
    tyEff   = iSof ? '0 : ty;

    absDiff = (iData >= prevPix) ? ({1'b0, iData} - {1'b0, prevPix})
                                 : ({1'b0, prevPix} - {1'b0, iData});
    edgeHit = (colEff != '0) && (32'(absDiff) > EDGE_THRESHOLD);

    // A SoF beat sees cleared counters, so its own contribution starts from zero.
    baseScore = iSof ? '0 : score[txEff];
    scoreNext = (edgeHit && (baseScore != {SW{1'b1}})) ? baseScore + SW'(1) : baseScore;

    tileDone = (rowEff == RW'(TILE_HEIGHT - 1)) && (colEff == CW'(TILE_WIDTH - 1));
    frameEnd = tileDone && (txEff == TXW'(TX - 1)) && (tyEff == TYW'(TY - 1));

    unique case (route_mode_e'(iMode))
      MODE_THRESHOLD:   routeCnn = (32'(scoreNext) >= ROUTING_THRESHOLD);
      MODE_FORCE_CNN:   routeCnn = 1'b1;
      MODE_FORCE_LIGHT: routeCnn = 1'b0;
      MODE_INVERTED:    routeCnn = (32'(scoreNext) < ROUTING_THRESHOLD);
      default:          routeCnn = 1'b0;
    endcase

    colNext = colEff;
    txNext  = txEff;
    rowNext = rowEff;
    tyNext  = tyEff;
    if (colEff == CW'(TILE_WIDTH - 1)) begin
      colNext = '0;
      if (txEff == TXW'(TX - 1)) begin
        txNext = '0;
        if (rowEff == RW'(TILE_HEIGHT - 1)) begin
          rowNext = '0;
          tyNext  = (tyEff == TYW'(TY - 1)) ? '0 : tyEff + TYW'(1);
        end else begin
          rowNext = rowEff + RW'(1);
        end
      end else begin
        txNext = txEff + TXW'(1);
      end
    end else begin
      colNext = colEff + CW'(1);
    end

    oReady = ~iRst & (qCount < CNTW'(DEC_DEPTH));
    push   = accept & tileDone & ~qFull;
    decIn  = {routeCnn, txEff, tyEff, scoreNext};
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      col        <= '0;
      tx         <= '0;
      row        <= '0;
      ty         <= '0;
      prevPix    <= '0;
      oFrameDone <= 1'b0;
      for (int unsigned i = 0; i < TX; i++) score[i] <= '0;
    end else begin
      oFrameDone <= accept & frameEnd;
      if (accept) begin
        col     <= colNext;
        tx      <= txNext;
        row     <= rowNext;
        ty      <= tyNext;
        prevPix <= iData;
        if (iSof) begin
          for (int unsigned i = 0; i < TX; i++) score[i] <= '0;
        end
        score[txEff] <= tileDone ? '0 : scoreNext;
      end
    end
  end

  route_decision_fifo #(
    .WIDTH (DW),
    .DEPTH (DEC_DEPTH)
  ) uDecisionFifo (
    .iClk   (iClk),
    .iRst   (iRst),
    .iPush  (push),
    .iData  (decIn),
    .iPop   (iDecReady),
    .oData  (decOut),
    .oFull  (qFull),
    .oEmpty (qEmpty),
    .oCount (qCount)
  );

  always_comb begin
    oDecValid = ~qEmpty;
    {oRouteToCnn, oTileX, oTileY, oScore} = decOut;
  end

endmodule

// File: tb/tb_tile_route_dispatcher.sv
// Directed bench for tile_route_dispatcher at default geometry (2x1 tiles of 16x16,
// 512 pixels per frame): table-driven frames plus backpressure, SoF and reset sequences.
module tb_tile_route_dispatcher;

  localparam int IMG_W = 32;
  localparam int FRAME = 512;

  logic       iClk = 1'b0;
  logic       iRst, iValid, iSof, iDecReady;
  logic [7:0] iData;
  logic [1:0] iMode;
  logic       oReady, oDecValid, oRouteToCnn, oFrameDone;
  logic       oTileX, oTileY;
  logic [7:0] oScore;

  always #5 iClk = ~iClk;

  tile_route_dispatcher #(
    .PIX_W(8), .IMG_WIDTH(32), .IMG_HEIGHT(16), .TILE_WIDTH(16), .TILE_HEIGHT(16),
    .EDGE_THRESHOLD(60), .ROUTING_THRESHOLD(80), .DEC_DEPTH(2)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iData(iData), .iValid(iValid), .iSof(iSof), .oReady(oReady),
    .iMode(iMode), .oDecValid(oDecValid), .iDecReady(iDecReady), .oRouteToCnn(oRouteToCnn),
    .oTileX(oTileX), .oTileY(oTileY), .oScore(oScore), .oFrameDone(oFrameDone)
  );

  typedef struct {
    int route;
    int tx;
    int ty;
    int score;
  } dec_t;

  typedef struct {
    string    name;
    int       pat;
    int       mode;
    int       r0;
    int       s0;
    int       r1;
    int       s1;
  } vec_t;

  dec_t cap[$];
  int   fdCount = 0;
  int   nChecks = 0;
  int   nErrors = 0;

  // Decisions are logged when consumed; frame-done pulses are counted.
  always @(negedge iClk) begin
    dec_t d;
    if (!iRst && oDecValid && iDecReady) begin
      d.route = int'(oRouteToCnn);
      d.tx    = int'(oTileX);
      d.ty    = int'(oTileY);
      d.score = int'(oScore);
      cap.push_back(d);
    end
    if (!iRst && oFrameDone) fdCount++;
  end

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // 0 flat; 1 tile0 alternating 00/FF, tile1 flat; 2 diff 60 everywhere; 3 diff 61 on 80 tile1 pixels.
  function automatic logic [7:0] pixVal(input int pat, input int x, input int y);
    case (pat)
      1:       return (x < 16) ? ((x % 2 != 0) ? 8'hFF : 8'h00) : 8'h40;
      2:       return (x % 2 != 0) ? 8'h3C : 8'h00;
      3: begin
        if (x < 16 || y > 5) return 8'd0;
        if (y < 5)           return (x % 2 != 0) ? 8'd61 : 8'd0;
        if (x <= 21)         return (x % 2 != 0) ? 8'd61 : 8'd0;
        return 8'd61;
      end
      default: return 8'h40;
    endcase
  endfunction

  task automatic sendPix(input logic [7:0] d, input logic sof);
    int t = 0;
    iData  = d;
    iSof   = sof;
    iValid = 1'b1;
    @(negedge iClk);
    while (!oReady && t < 200) begin
      @(negedge iClk);
      t++;
    end
    if (!oReady) check("beat_accept_timeout", int'(oReady), 1);
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    iSof   = 1'b0;
  endtask

  task automatic sendFrame(input int pat, input logic sofFirst, input int nPix);
    for (int p = 0; p < nPix; p++)
      sendPix(pixVal(pat, p % IMG_W, p / IMG_W), sofFirst && (p == 0));
  endtask

  task automatic settle(input int target);
    int t = 0;
    repeat (3) begin @(posedge iClk); #1; end
    while (cap.size() < target && t < 50) begin
      @(posedge iClk);
      #1;
      t++;
    end
  endtask

  task automatic checkDec(input string name, input int idx, input int r, input int x, input int s);
    if (cap.size() > idx) begin
      check({name, ".route"}, cap[idx].route, r);
      check({name, ".tileX"}, cap[idx].tx, x);
      check({name, ".tileY"}, cap[idx].ty, 0);
      check({name, ".score"}, cap[idx].score, s);
    end
  endtask

  task automatic checkFrame(input vec_t v, input int base, input int fdBase);
    check({v.name, ".decisions"}, cap.size() - base, 2);
    check({v.name, ".frameDone"}, fdCount - fdBase, 1);
    checkDec({v.name, ".d0"}, base, v.r0, 0, v.s0);
    checkDec({v.name, ".d1"}, base + 1, v.r1, 1, v.s1);
  endtask

  task automatic runVector(input vec_t v);
    int base   = cap.size();
    int fdBase = fdCount;
    iMode      = v.mode[1:0];
    iDecReady  = 1'b1;
    sendFrame(v.pat, 1'b0, FRAME);
    settle(base + 2);
    checkFrame(v, base, fdBase);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".oReady"},      int'(oReady), 0);
    check({tag, ".oDecValid"},   int'(oDecValid), 0);
    check({tag, ".oRouteToCnn"}, int'(oRouteToCnn), 0);
    check({tag, ".oTileX"},      int'(oTileX), 0);
    check({tag, ".oTileY"},      int'(oTileY), 0);
    check({tag, ".oScore"},      int'(oScore), 0);
    check({tag, ".oFrameDone"},  int'(oFrameDone), 0);
  endtask

  vec_t vecs[7];
  vec_t pat2Ref;

  initial begin
    int base, fdBase;
    vecs[0] = '{"flat",      0, 0, 0, 0,   0, 0};
    vecs[1] = '{"alt",       1, 0, 1, 240, 0, 0};
    vecs[2] = '{"diff60",    2, 0, 0, 0,   0, 0};
    vecs[3] = '{"diff61",    3, 0, 0, 0,   1, 80};
    vecs[4] = '{"forceCnn",  1, 1, 1, 240, 1, 0};
    vecs[5] = '{"forceLite", 1, 2, 0, 240, 0, 0};
    vecs[6] = '{"inverted",  1, 3, 0, 240, 1, 0};
    pat2Ref = vecs[1];

    iRst = 1'b1; iValid = 1'b0; iSof = 1'b0; iData = '0; iMode = '0; iDecReady = 1'b1;
    @(negedge iClk);
    checkResetOutputs("reset0");
    @(posedge iClk); #1;
    iRst = 1'b0;

    foreach (vecs[i]) runVector(vecs[i]);

    // Backpressure: two frames with the consumer stalled, then released.
    base = cap.size(); fdBase = fdCount;
    iMode = 2'd0; iDecReady = 1'b0;
    sendFrame(1, 1'b0, FRAME);
    iValid = 1'b1; iData = pixVal(0, 0, 0); iSof = 1'b0;
    repeat (8) begin
      @(negedge iClk);
      check("bp.readyLow", int'(oReady), 0);
      check("bp.headValid", int'(oDecValid), 1);
      check("bp.headTileX", int'(oTileX), 0);
      check("bp.headScore", int'(oScore), 240);
    end
    check("bp.noneConsumed", cap.size() - base, 0);
    @(posedge iClk); #1;
    iDecReady = 1'b1;
    sendFrame(0, 1'b0, FRAME);
    settle(base + 4);
    check("bp.decisions", cap.size() - base, 4);
    check("bp.frameDone", fdCount - fdBase, 2);
    checkDec("bp.f1d0", base,     1, 0, 240);
    checkDec("bp.f1d1", base + 1, 0, 1, 0);
    checkDec("bp.f2d0", base + 2, 0, 0, 0);
    checkDec("bp.f2d1", base + 3, 0, 1, 0);

    // SoF resync after a partial frame.
    base = cap.size(); fdBase = fdCount;
    sendFrame(1, 1'b0, 100);
    sendFrame(1, 1'b1, FRAME);
    settle(base + 2);
    pat2Ref.name = "sof";
    checkFrame(pat2Ref, base, fdBase);

    // Reset in the middle of a frame.
    sendFrame(1, 1'b0, 300);
    iRst = 1'b1; iValid = 1'b1; iData = 8'hFF;
    @(negedge iClk);
    checkResetOutputs("rstMid");
    @(posedge iClk); #1;
    iRst = 1'b0; iValid = 1'b0;
    pat2Ref.name = "afterRstMid";
    runVector(pat2Ref);

    // Reset with a full decision queue discards the queued decisions.
    iDecReady = 1'b0;
    sendFrame(0, 1'b0, FRAME);
    @(negedge iClk);
    check("rstQ.queuedBefore", int'(oDecValid), 1);
    @(posedge iClk); #1;
    iRst = 1'b1;
    @(negedge iClk);
    checkResetOutputs("rstQ");
    @(posedge iClk); #1;
    iRst = 1'b0;
    @(negedge iClk);
    check("rstQ.emptyAfter", int'(oDecValid), 0);
    @(posedge iClk); #1;
    pat2Ref.name = "afterRstQ";
    runVector(pat2Ref);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
